ysyx_22040088_lsu: RTL and testbench
====================================

# ysyx_22040088_lsu

Load/store unit sitting directly downstream of the control unit in the NPC core. It consumes the decoded memory controls (`mem_ena`, `mem_wen`, `mem_mask`, `sel_rfres`) together with the ALU-computed address and the store data. It runs one memory transaction at a time over a valid/ready request and valid response interface to a 64-bit data memory. It returns a sign- or zero-extended load result for the register-file write-back mux.

## Interface
Parameters:
- `AW`, 64: address width.
- `DW`, 64: data width; fixed at 64, and the 8-byte lane logic depends on it.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers a memory instruction; qualified by `mem_ena`.
- `in_ready`  out  1  LSU can accept a new request.
- `mem_ena`  in  1  instruction is a load or store.
- `mem_wen`  in  1  1 = store, 0 = load.
- `mem_mask`  in  4  one-hot access size: 0001 = double, 0010 = word, 0100 = half, 1000 = byte.
- `sel_rfres`  in  3  bit2 = unsigned load, bit1 = signed load, bit0 = non-load.
- `addr`  in  AW  effective byte address.
- `wdata`  in  DW  store data, right-aligned.
- `dmem_req_valid`  out  1  memory request.
- `dmem_req_ready`  in  1  memory accepts the request.
- `dmem_addr`  out  AW  address aligned down to 8 bytes (low 3 bits are 0).
- `dmem_we`  out  1  write request.
- `dmem_wstrb`  out  8  byte write strobes.
- `dmem_wdata`  out  DW  store data shifted to its byte lanes.
- `dmem_rsp_valid`  in  1  memory response; one-cycle pulse.
- `dmem_rdata`  in  DW  aligned 64-bit read data.
- `out_valid`  out  1  one-cycle completion pulse.
- `out_rdata`  out  DW  extended load result; 0 for stores and errors.
- `out_err`  out  1  qualified by `out_valid`; request was not performed.

## Operation
- State machine states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `in_ready` is 1.
  - If `in_valid & mem_ena`, latch `addr`, `wdata`, `mem_wen`, `mem_mask` and `sel_rfres[2]`, then go to REQ.
  - If the request is erroneous, go to DONE with the error flag set instead.
  - `in_valid` with `mem_ena` = 0 is ignored.
- REQ:
  - `dmem_req_valid` is 1 and all `dmem_*` outputs are held stable.
  - Go to WAIT on `dmem_req_ready`.
- WAIT:
  - Go to DONE on `dmem_rsp_valid`, capturing `dmem_rdata`.
  - A `dmem_rsp_valid` seen outside WAIT is ignored.
- DONE: `out_valid` is 1 for exactly one cycle, then return to IDLE.
- Byte lanes (with `off = addr[2:0]`):
  - `dmem_wstrb` = size mask (0xFF, 0x0F, 0x03 or 0x01) << `off`.
  - `dmem_wdata` = `wdata` << (8·`off`).
- Load extraction:
  - `r = dmem_rdata >> (8·off)`, truncated to the access size.
  - Then sign-extended if `sel_rfres[2]` = 0, zero-extended if it is 1.
  - Double accesses ignore the extension bit.
- Stores:
  - Still wait for `dmem_rsp_valid` (write acknowledge).
  - Complete with `out_rdata` = 0.
- Error cases:
  - `mem_mask` that is not one-hot, including 0000: no memory access; DONE with `out_err` = 1 and `out_rdata` = 0.
  - Misalignment is handled as described under Configuration.

## Timing
- Reset values: state IDLE, `in_ready` 1, `dmem_req_valid` 0, `dmem_we` 0, `dmem_wstrb` 0, `dmem_addr` 0, `dmem_wdata` 0, `out_valid` 0, `out_rdata` 0, `out_err` 0.
- Every output is registered or decoded from the state register; there is no combinational path from input to output.
- Minimum latency is 3 cycles after the accept edge:
  - Accept at edge 0.
  - REQ during cycle 1; `dmem_req_ready` = 1 in that cycle.
  - WAIT in cycle 2; `dmem_rsp_valid` = 1 in that cycle.
  - `out_valid` in cycle 3.
- Error completion: `out_valid` in the cycle after accept.
- Only one transaction is outstanding; `in_ready` is 0 in REQ, WAIT and DONE.
- Asserting `rst_n` low at any point, including mid-REQ or mid-WAIT, immediately forces the reset values. The pending transaction is dropped, and a late `dmem_rsp_valid` after reset is ignored.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - An access with `addr` not a multiple of its size (half: bit 0 ≠ 0; word: bits [1:0] ≠ 0; double: bits [2:0] ≠ 0) takes the error path.
  - Result: no memory request, `out_err` = 1, `out_rdata` = 0.
- Not defined:
  - Misalignment is not checked; the low address bits below the access size are forced to 0 before lane computation.
  - `out_err` is raised only for an invalid `mem_mask`.

## Test plan
- Load byte, signed: `addr` = 0x8000_0003, `mask` 1000, `sel_rfres` 010, `dmem_rdata` = 0x0000_0000_8000_0000. Expect `dmem_addr` 0x8000_0000 and `out_rdata` 0xFFFF_FFFF_FFFF_FF80.
- Load half, unsigned: `addr` 0x…6, `mask` 0100, `sel_rfres` 100, `rdata` 0xABCD_0000_0000_0000. Expect `out_rdata` 0x0000_0000_0000_ABCD.
- Store word: `addr` 0x…4, `wdata` 0x1122_3344. Expect `dmem_wstrb` 0xF0, `dmem_wdata` 0x1122_3344_0000_0000, `dmem_we` 1. After ack, `out_valid` with `out_rdata` 0.
- Backpressure: hold `dmem_req_ready` = 0 for 5 cycles. Expect `dmem_req_valid` and address/data stable throughout, `in_ready` 0, and exactly one `out_valid`.
- Misaligned word at `addr` 0x…2:
  - With the macro: `out_valid` + `out_err` one cycle after accept, and no `dmem_req_valid`.
  - Without the macro: access at lanes 0–3, `out_err` 0.
- Reset in WAIT: drop `rst_n` for 1 cycle, then pulse `dmem_rsp_valid`. Expect no `out_valid`, `in_ready` 1, all outputs at reset values.

Source files
------------

// File: rtl/ysyx_22040088_lsu.sv
// ============================================================================
// Module   : ysyx_22040088_lsu
// Purpose  : Load/store unit for the NPC core. Runs one memory transaction
//            at a time over a valid/ready request and valid response
//            interface to a 64-bit data memory. Returns a sign- or
//            zero-extended load result for the register-file write-back.
// Config   : LSU_MISALIGN_CHECK_EN - when defined, misaligned half, word and
//            double accesses take the error path. When undefined, the
//            address bits below the access size are ignored.
// Ports    : clk, rst_n (async, active low)
//            upstream   : in_valid, in_ready, mem_ena, mem_wen, mem_mask,
//                         sel_rfres, addr, wdata
//            memory req : dmem_req_valid, dmem_req_ready, dmem_addr,
//                         dmem_we, dmem_wstrb, dmem_wdata
//            memory rsp : dmem_rsp_valid, dmem_rdata
//            completion : out_valid, out_rdata, out_err
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040088_lsu #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mem_ena,
  input  logic          mem_wen,
  input  logic [3:0]    mem_mask,
  input  logic [2:0]    sel_rfres,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          dmem_req_valid,
  input  logic          dmem_req_ready,
  output logic [AW-1:0] dmem_addr,
  output logic          dmem_we,
  output logic [7:0]    dmem_wstrb,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_rsp_valid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_rdata,
  output logic          out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_dmem_addr;
  logic          r_dmem_we;
  logic [7:0]    r_dmem_wstrb;
  logic [DW-1:0] r_dmem_wdata;
  logic [3:0]    r_mask;
  logic          r_unsigned;
  logic [2:0]    r_off;
  logic [DW-1:0] r_out_rdata;
  logic          r_out_err;

  logic          w_mask_ok;
  logic          w_err;
  logic [2:0]    w_off;
  logic [7:0]    w_size_strb;
  logic [DW-1:0] w_rshift;
  logic [DW-1:0] w_load;
  logic          w_unused;

  // Only the unsigned-load bit matters here; the rest of the select
  // vector belongs to the write-back mux.
  assign w_unused = &{1'b0, sel_rfres[1:0]};

  // Size decode. The byte offset has the bits below the access size
  // cleared, so an unchecked misaligned access lands on its natural lanes.
  always_comb begin
    w_mask_ok   = 1'b1;
    w_size_strb = 8'h00;
    w_off       = 3'b000;
    case (mem_mask)
      4'b0001: begin w_size_strb = 8'hFF; w_off = 3'b000;                end
      4'b0010: begin w_size_strb = 8'h0F; w_off = {addr[2], 2'b00};      end
      4'b0100: begin w_size_strb = 8'h03; w_off = {addr[2:1], 1'b0};     end
      4'b1000: begin w_size_strb = 8'h01; w_off = addr[2:0];             end
      default: begin w_mask_ok   = 1'b0;                                 end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = (mem_mask[0] & (|addr[2:0])) |
                      (mem_mask[1] & (|addr[1:0])) |
                      (mem_mask[2] & addr[0]);
  assign w_err = ~w_mask_ok | w_misalign;
`else
  assign w_err = ~w_mask_ok;
`endif

  // Load extraction from the aligned response word.
  assign w_rshift = dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = w_rshift;
    case (r_mask)
      4'b0010: w_load = r_unsigned ? {{(DW-32){1'b0}}, w_rshift[31:0]}
                                   : {{(DW-32){w_rshift[31]}}, w_rshift[31:0]};
      4'b0100: w_load = r_unsigned ? {{(DW-16){1'b0}}, w_rshift[15:0]}
                                   : {{(DW-16){w_rshift[15]}}, w_rshift[15:0]};
      4'b1000: w_load = r_unsigned ? {{(DW-8){1'b0}}, w_rshift[7:0]}
                                   : {{(DW-8){w_rshift[7]}}, w_rshift[7:0]};
      default: w_load = w_rshift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_dmem_addr  <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_wstrb <= 8'h00;
      r_dmem_wdata <= '0;
      r_mask       <= 4'b0000;
      r_unsigned   <= 1'b0;
      r_off        <= 3'b000;
      r_out_rdata  <= '0;
      r_out_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && mem_ena) begin
            if (w_err) begin
              // Rejected request: complete immediately without touching memory.
              r_out_rdata <= '0;
              r_out_err   <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_dmem_addr  <= {addr[AW-1:3], 3'b000};
              r_dmem_we    <= mem_wen;
              r_dmem_wstrb <= w_size_strb << w_off;
              r_dmem_wdata <= wdata << {w_off, 3'b000};
              r_mask       <= mem_mask;
              r_unsigned   <= sel_rfres[2];
              r_off        <= w_off;
              r_state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rsp_valid) begin
            // Store acknowledges carry no result.
            r_out_rdata <= r_dmem_we ? '0 : w_load;
            r_out_err   <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready       = (r_state == S_IDLE);
  assign dmem_req_valid = (r_state == S_REQ);
  assign out_valid      = (r_state == S_DONE);
  assign dmem_addr      = r_dmem_addr;
  assign dmem_we        = r_dmem_we;
  assign dmem_wstrb     = r_dmem_wstrb;
  assign dmem_wdata     = r_dmem_wdata;
  assign out_rdata      = r_out_rdata;
  assign out_err        = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040088_lsu.sv
// ============================================================================
// Module   : tb_ysyx_22040088_lsu
// Purpose  : Directed self-checking bench for ysyx_22040088_lsu. Expected
//            completions are queued as stimulus is issued; a monitor pops
//            and compares them whenever out_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040088_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mem_ena;
  logic        mem_wen;
  logic [3:0]  mem_mask;
  logic [2:0]  sel_rfres;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [63:0] dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wstrb;
  logic [63:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rdata;
  logic        out_valid;
  logic [63:0] out_rdata;
  logic        out_err;

  ysyx_22040088_lsu #(.AW(64), .DW(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_ena        (mem_ena),
    .mem_wen        (mem_wen),
    .mem_mask       (mem_mask),
    .sel_rfres      (sel_rfres),
    .addr           (addr),
    .wdata          (wdata),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .out_valid      (out_valid),
    .out_rdata      (out_rdata),
    .out_err        (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  // Completion monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_out++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid got rdata=%h err=%b required no completion",
                 out_rdata, out_err);
      end else begin
        mon_e = sb.pop_front();
        if (out_rdata !== mon_e.rdata || out_err !== mon_e.err) begin
          errors++;
          $display("FAIL out_rsp got rdata=%h err=%b required rdata=%h err=%b",
                   out_rdata, out_err, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"},  in_ready,       64'd1);
    chk({nm, "_req_valid"}, dmem_req_valid, 64'd0);
    chk({nm, "_we"},        dmem_we,        64'd0);
    chk({nm, "_wstrb"},     dmem_wstrb,     64'd0);
    chk({nm, "_addr"},      dmem_addr,      64'd0);
    chk({nm, "_wdata"},     dmem_wdata,     64'd0);
    chk({nm, "_out_valid"}, out_valid,      64'd0);
    chk({nm, "_out_rdata"}, out_rdata,      64'd0);
    chk({nm, "_out_err"},   out_err,        64'd0);
  endtask

  // One transaction from accept to return to IDLE. Inputs are scrambled
  // after the accept edge so any use of unlatched inputs shows up.
  task automatic txn(input string nm, input logic [63:0] a, input logic [63:0] wd,
                     input logic wen, input logic [3:0] mask, input logic [2:0] sel,
                     input logic [63:0] rd, input int stall, input logic exp_req,
                     input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                     input logic [63:0] exp_wdata, input logic [63:0] exp_out,
                     input logic exp_err);
    int n0;
    n0 = n_out;
    chk({nm, "_in_ready_idle"}, in_ready, 64'd1);
    in_valid  = 1'b1;
    mem_ena   = 1'b1;
    mem_wen   = wen;
    mem_mask  = mask;
    sel_rfres = sel;
    addr      = a;
    wdata     = wd;
    sb.push_back(rsp_t'({exp_out, exp_err}));
    tick();
    in_valid  = 1'b0;
    mem_ena   = 1'b0;
    mem_wen   = ~wen;
    mem_mask  = 4'b1111;
    sel_rfres = ~sel;
    addr      = ~a;
    wdata     = ~wd;
    if (exp_req) begin
      for (int i = 0; i <= stall; i++) begin
        dmem_req_ready = (i == stall);
        chk({nm, "_req_valid"}, dmem_req_valid, 64'd1);
        chk({nm, "_in_ready_busy"}, in_ready, 64'd0);
        chk({nm, "_dmem_addr"}, dmem_addr, exp_addr);
        chk({nm, "_dmem_we"}, dmem_we, {63'd0, wen});
        chk({nm, "_dmem_wstrb"}, dmem_wstrb, {56'd0, exp_strb});
        chk({nm, "_dmem_wdata"}, dmem_wdata, exp_wdata);
        tick();
      end
      dmem_req_ready = 1'b0;
      chk({nm, "_req_dropped"}, dmem_req_valid, 64'd0);
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = rd;
      tick();
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = 64'h5A5A_A5A5_5A5A_A5A5;
    end else begin
      chk({nm, "_no_req"}, dmem_req_valid, 64'd0);
    end
    tick();
    chk({nm, "_back_idle"}, in_ready, 64'd1);
    chk({nm, "_drained"}, sb.size(), 64'd0);
    chk({nm, "_one_out"}, n_out - n0, 64'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    mem_ena        = 1'b0;
    mem_wen        = 1'b0;
    mem_mask       = 4'b0000;
    sel_rfres      = 3'b000;
    addr           = '0;
    wdata          = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = '0;
    repeat (3) tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    //   name       addr                   wdata                  we    mask     sel     rdata                 stall req  exp_addr              strb   exp_wdata              exp_out                err
    txn("lb_s",   64'h0000_0000_8000_0003, 64'h0,                 1'b0, 4'b1000, 3'b010, 64'h0000_0000_8000_0000, 0, 1'b1, 64'h0000_0000_8000_0000, 8'h08, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    txn("lhu",    64'h0000_0000_8000_0006, 64'h0,                 1'b0, 4'b0100, 3'b100, 64'hABCD_0000_0000_0000, 0, 1'b1, 64'h0000_0000_8000_0000, 8'hC0, 64'h0,                 64'h0000_0000_0000_ABCD, 1'b0);
    txn("sw",     64'h0000_0000_8000_0004, 64'h0000_0000_1122_3344, 1'b1, 4'b0010, 3'b001, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b1, 64'h0000_0000_8000_0000, 8'hF0, 64'h1122_3344_0000_0000, 64'h0,                 1'b0);
    txn("ld_bp",  64'h0000_0000_8000_0010, 64'h0,                 1'b0, 4'b0001, 3'b100, 64'h0123_4567_89AB_CDEF, 5, 1'b1, 64'h0000_0000_8000_0010, 8'hFF, 64'h0,                 64'h0123_4567_89AB_CDEF, 1'b0);
    txn("lw_s",   64'h0000_0000_8000_000C, 64'h0,                 1'b0, 4'b0010, 3'b010, 64'h8765_4321_0000_0000, 1, 1'b1, 64'h0000_0000_8000_0008, 8'hF0, 64'h0,                 64'hFFFF_FFFF_8765_4321, 1'b0);
    txn("lh_pos", 64'h0000_0000_8000_0002, 64'h0,                 1'b0, 4'b0100, 3'b010, 64'h0000_0000_7FFF_0000, 0, 1'b1, 64'h0000_0000_8000_0000, 8'h0C, 64'h0,                 64'h0000_0000_0000_7FFF, 1'b0);
    txn("lbu",    64'h0000_0000_8000_0005, 64'h0,                 1'b0, 4'b1000, 3'b100, 64'h0000_FF00_0000_0000, 0, 1'b1, 64'h0000_0000_8000_0000, 8'h20, 64'h0,                 64'h0000_0000_0000_00FF, 1'b0);
    txn("sb_top", 64'h0000_0000_8000_0007, 64'h0000_0000_0000_00AB, 1'b1, 4'b1000, 3'b001, 64'h1111_2222_3333_4444, 2, 1'b1, 64'h0000_0000_8000_0000, 8'h80, 64'hAB00_0000_0000_0000, 64'h0,                 1'b0);
    txn("mask0",  64'h0000_0000_8000_0000, 64'h0,                 1'b0, 4'b0000, 3'b010, 64'h0,                 0, 1'b0, 64'h0,                 8'h00, 64'h0,                 64'h0,                 1'b1);
    txn("mask3",  64'h0000_0000_8000_0008, 64'h0,                 1'b1, 4'b0011, 3'b001, 64'h0,                 0, 1'b0, 64'h0,                 8'h00, 64'h0,                 64'h0,                 1'b1);
`ifdef LSU_MISALIGN_CHECK_EN
    txn("lw_mis", 64'h0000_0000_8000_0002, 64'h0,                 1'b0, 4'b0010, 3'b010, 64'h0000_0000_1234_5678, 0, 1'b0, 64'h0,                 8'h00, 64'h0,                 64'h0,                 1'b1);
`else
    txn("lw_mis", 64'h0000_0000_8000_0002, 64'h0,                 1'b0, 4'b0010, 3'b010, 64'h0000_0000_1234_5678, 0, 1'b1, 64'h0000_0000_8000_0000, 8'h0F, 64'h0,                 64'h0000_0000_1234_5678, 1'b0);
`endif

    // in_valid without mem_ena is ignored
    in_valid = 1'b1;
    mem_ena  = 1'b0;
    mem_mask = 4'b0001;
    addr     = 64'h0000_0000_8000_0020;
    tick();
    in_valid = 1'b0;
    chk("noena_in_ready", in_ready, 64'd1);
    chk("noena_req_valid", dmem_req_valid, 64'd0);
    tick();
    chk("noena_out_valid", out_valid, 64'd0);

    // Reset while waiting for the response, then a late response
    in_valid  = 1'b1;
    mem_ena   = 1'b1;
    mem_wen   = 1'b1;
    mem_mask  = 4'b0001;
    sel_rfres = 3'b001;
    addr      = 64'h0000_0000_8000_0040;
    wdata     = 64'hCAFE_F00D_CAFE_F00D;
    tick();
    in_valid       = 1'b0;
    mem_ena        = 1'b0;
    dmem_req_ready = 1'b1;
    chk("rstw_req_valid", dmem_req_valid, 64'd1);
    tick();
    dmem_req_ready = 1'b0;
    chk("rstw_in_wait", dmem_req_valid, 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstw_async");
    tick();
    rst_n          = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 64'h7777_7777_7777_7777;
    tick();
    dmem_rsp_valid = 1'b0;
    chk_reset_vals("rstw_late_rsp");
    tick();
    chk_reset_vals("rstw_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
